// File: rtl/vga_timing_gen_if.sv
// Raster bus between the VGA timing generator and the pixel source / DAC side.
// Adds patternSel when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
  parameter int unsigned HW      = 10,
  parameter int unsigned VW      = 10,
  parameter int unsigned COLOR_W = 1
) ();
  logic [HW-1:0]      hcount;
  logic [VW-1:0]      vcount;
  logic [HW-1:0]      x;
  logic [VW-1:0]      y;
  logic               lineStart;
  logic               frameStart;
  logic [COLOR_W-1:0] redIn;
  logic [COLOR_W-1:0] greenIn;
  logic [COLOR_W-1:0] blueIn;
  logic [COLOR_W-1:0] redOut;
  logic [COLOR_W-1:0] greenOut;
  logic [COLOR_W-1:0] blueOut;
  logic               hSync;
  logic               vSync;
  logic               de;
`ifdef VGA_TEST_PATTERN_EN
  logic               patternSel;
`endif

  modport master (
`ifdef VGA_TEST_PATTERN_EN
    input  patternSel,
`endif
    input  redIn, greenIn, blueIn,
    output hcount, vcount, x, y, lineStart, frameStart,
    output redOut, greenOut, blueOut, hSync, vSync, de
  );

  modport slave (
`ifdef VGA_TEST_PATTERN_EN
    output patternSel,
`endif
    output redIn, greenIn, blueIn,
    input  hcount, vcount, x, y, lineStart, frameStart,
    input  redOut, greenOut, blueOut, hSync, vSync, de
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with aligned, blanked RGB output.
// Define VGA_TEST_PATTERN_EN to add the patternSel input and internal colour bars.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          HSYNC_POL   = 1'b0,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int unsigned COLOR_W     = 1,
  parameter int unsigned PIX_LATENCY = 1
) (
  input logic               clk25175KHz,
  input logic               reset,
  vga_timing_gen_if.master  bus
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYN_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYN_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYN_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYN_E = VW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned DW = 7;
`else
  localparam int unsigned DW = 3;
`endif

  if (PIX_LATENCY > 3) begin : g_bad_lat
    $error("vga_timing_gen: PIX_LATENCY must be 0..3");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing_gen: timing parameters must be non-zero");
  end

  logic          r_run;
  logic [HW-1:0] r_hc;
  logic [VW-1:0] r_vc;

  // r_run holds the counters at 0,0 for the first cycle after reset release.
  always_ff @(posedge clk25175KHz) begin
    if (reset) begin
      r_run <= 1'b0;
      r_hc  <= '0;
      r_vc  <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (r_hc == H_LAST) begin
          r_hc <= '0;
          r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
        end else begin
          r_hc <= r_hc + 1'b1;
        end
      end
    end
  end

  logic          w_act, w_hs, w_vs, w_line, w_frame;
  logic [HW-1:0] w_x;
  logic [VW-1:0] w_y;

  assign w_act   = r_run && (r_hc < H_ACT) && (r_vc < V_ACT);
  assign w_hs    = r_run && (r_hc >= H_SYN_S) && (r_hc < H_SYN_E);
  assign w_vs    = r_run && (r_vc >= V_SYN_S) && (r_vc < V_SYN_E);
  assign w_line  = r_run && (r_hc == '0);
  assign w_frame = w_line && (r_vc == '0);
  assign w_x     = (r_hc < H_ACT) ? r_hc : '0;
  assign w_y     = (r_vc < V_ACT) ? r_vc : '0;

  logic [DW-1:0] w_stage_in, w_stage_out;

`ifdef VGA_TEST_PATTERN_EN
  logic          r_psel;
  logic          w_sel;
  logic [HW+2:0] w_x8;
  logic [2:0]    w_bar;

  // The frameStart pixel itself already uses the newly sampled selection.
  assign w_sel = w_frame ? bus.patternSel : r_psel;
  assign w_x8  = {w_x, 3'b000};
  assign w_bar = 3'(w_x8 / (HW + 3)'(H_ACTIVE));

  always_ff @(posedge clk25175KHz) begin
    if (reset) begin
      r_psel <= 1'b0;
    end else if (w_frame) begin
      r_psel <= bus.patternSel;
    end
  end

  assign w_stage_in = {w_sel, w_bar, w_act, w_hs, w_vs};
`else
  assign w_stage_in = {w_act, w_hs, w_vs};
`endif

  if (PIX_LATENCY == 0) begin : g_no_dly
    assign w_stage_out = w_stage_in;
  end else begin : g_dly
    logic [PIX_LATENCY*DW-1:0] r_dly;
    always_ff @(posedge clk25175KHz) begin
      if (reset) begin
        r_dly <= '0;
      end else begin
        r_dly <= (PIX_LATENCY * DW)'({r_dly, w_stage_in});
      end
    end
    assign w_stage_out = r_dly[PIX_LATENCY*DW-1 -: DW];
  end

  logic               w_de_next;
  logic [COLOR_W-1:0] w_r, w_g, w_b;
  assign w_de_next = w_stage_out[2];

`ifdef VGA_TEST_PATTERN_EN
  assign w_r = w_stage_out[6] ? {COLOR_W{w_stage_out[5]}} : bus.redIn;
  assign w_g = w_stage_out[6] ? {COLOR_W{w_stage_out[4]}} : bus.greenIn;
  assign w_b = w_stage_out[6] ? {COLOR_W{w_stage_out[3]}} : bus.blueIn;
`else
  assign w_r = bus.redIn;
  assign w_g = bus.greenIn;
  assign w_b = bus.blueIn;
`endif

  logic               r_de, r_hsync, r_vsync;
  logic [COLOR_W-1:0] r_red, r_green, r_blue;

  always_ff @(posedge clk25175KHz) begin
    if (reset) begin
      r_de    <= 1'b0;
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_de    <= w_de_next;
      r_hsync <= w_stage_out[1] ? HSYNC_POL : ~HSYNC_POL;
      r_vsync <= w_stage_out[0] ? VSYNC_POL : ~VSYNC_POL;
      r_red   <= w_de_next ? w_r : '0;
      r_green <= w_de_next ? w_g : '0;
      r_blue  <= w_de_next ? w_b : '0;
    end
  end

  assign bus.hcount     = r_hc;
  assign bus.vcount     = r_vc;
  assign bus.x          = w_x;
  assign bus.y          = w_y;
  assign bus.lineStart  = w_line;
  assign bus.frameStart = w_frame;
  assign bus.de         = r_de;
  assign bus.hSync      = r_hsync;
  assign bus.vSync      = r_vsync;
  assign bus.redOut     = r_red;
  assign bus.greenOut   = r_green;
  assign bus.blueOut    = r_blue;
endmodule
